module_reg_access_ctrl: RTL and testbench

Parametrised register-bank access controller for the SPI peripheral. It generalises the fixed control/data write-enable demux into N addressable registers. It accepts single read/write requests and produces registered one-hot write strobes and registered read-back data, then returns an ack/err handshake. It sits between the host-side request port and the SPI register bank (control, data, status, ...).

---
 rtl/spi_regs_pkg.sv | 14 +
 rtl/module_reg_access_ctrl_if.sv | 35 +++
 rtl/module_onehot_decoder.sv | 19 +
 rtl/module_reg_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_module_reg_access_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_regs_pkg.sv
// Shared types and constants for the SPI register-bank access controller.
// Holds the FSM state encoding and the error-counter width and saturation value.
package spi_regs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/module_reg_access_ctrl_if.sv
// Host request/response port and register-bank strobe/read-back bus of the access controller.
// The slave modport is the controller side; the master modport is the host/bank side.
interface module_reg_access_ctrl_if
    import spi_regs_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 32
) ();

    logic                         req_i;
    logic                         we_i;
    logic [ADDR_W-1:0]            addr_i;
    logic [DATA_W-1:0]            wdata_i;
    logic                         err_clr_i;
    logic [NUM_REGS*DATA_W-1:0]   rd_data_i;
    logic [NUM_REGS-1:0]          wr_en_o;
    logic [DATA_W-1:0]            wr_data_o;
    logic [DATA_W-1:0]            rdata_o;
    logic                         ack_o;
    logic                         err_o;
    logic                         busy_o;
    logic [ERR_CNT_W-1:0]         err_cnt_o;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, err_clr_i, rd_data_i,
        output wr_en_o, wr_data_o, rdata_o, ack_o, err_o, busy_o, err_cnt_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, err_clr_i, rd_data_i,
        input  wr_en_o, wr_data_o, rdata_o, ack_o, err_o, busy_o, err_cnt_o
    );

endinterface

// File: rtl/module_onehot_decoder.sv
// Combinational address-to-one-hot decoder; zero output when disabled or addr_i >= N.
// No latency, no backpressure.
module module_onehot_decoder #(
    parameter int N      = 4,
    parameter int ADDR_W = 2
) (
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [N-1:0]      onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            onehot_o[i] = en_i && (addr_i == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/module_reg_access_ctrl.sv
// Register-bank access controller: one request -> registered strobe (k+1) -> ack/err (k+2).
// No queuing: requests arriving while busy are ignored; requester must hold or re-issue.
module module_reg_access_ctrl
    import spi_regs_pkg::*;
#(
    parameter int                  NUM_REGS = 4,
    parameter int                  ADDR_W   = 2,
    parameter int                  DATA_W   = 32,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    module_reg_access_ctrl_if.slave   bus
);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 we_q, we_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 err_q, err_d;
    logic [NUM_REGS-1:0]  wr_en_q, wr_en_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 ack_q, ack_d;
    logic                 err_out_q, err_out_d;
    logic                 busy_q, busy_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 ro_hit;
    logic                 req_err;
    logic                 err_inc;
    logic                 dec_en;
    logic [NUM_REGS-1:0]  dec_onehot;
    logic [DATA_W-1:0]    rd_sel;

    // Decode by equality so out-of-range addresses never index RO_MASK or rd_data_i.
    always_comb begin
        ro_hit = 1'b0;
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.addr_i == ADDR_W'(i)) ro_hit = RO_MASK[i];
            if (addr_q == ADDR_W'(i))     rd_sel = bus.rd_data_i[i*DATA_W +: DATA_W];
        end
        req_err = (32'(bus.addr_i) >= NUM_REGS) || (bus.we_i && ro_hit);
        dec_en  = (state_q == IDLE) && bus.req_i && bus.we_i && !req_err;
    end

    module_onehot_decoder #(
        .N      (NUM_REGS),
        .ADDR_W (ADDR_W)
    ) u_dec (
        .en_i     (dec_en),
        .addr_i   (bus.addr_i),
        .onehot_o (dec_onehot)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        wr_en_d   = '0;
        wr_data_d = wr_data_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
        err_out_d = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    state_d = EXEC;
                    addr_d  = bus.addr_i;
                    we_d    = bus.we_i;
                    wdata_d = bus.wdata_i;
                    err_d   = req_err;
                    busy_d  = 1'b1;
                    wr_en_d = dec_onehot;
                    if (dec_en) wr_data_d = bus.wdata_i;
                end
            end
            EXEC: begin
                state_d   = RESP;
                ack_d     = 1'b1;
                err_out_d = err_q;
                if (!we_q) rdata_d = err_q ? '0 : rd_sel;
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // A clear coinciding with an increment leaves the count at one, not zero.
    always_comb begin
        err_inc   = (state_q == EXEC) && err_q;
        err_cnt_d = err_cnt_q;
        if (bus.err_clr_i) begin
            err_cnt_d = err_inc ? ERR_CNT_W'(1) : '0;
        end else if (err_inc && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            err_out_q <= 1'b0;
            busy_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            err_out_q <= err_out_d;
            busy_q    <= busy_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.wr_en_o   = wr_en_q;
    assign bus.wr_data_o = wr_data_q;
    assign bus.rdata_o   = rdata_q;
    assign bus.ack_o     = ack_q;
    assign bus.err_o     = err_out_q;
    assign bus.busy_o    = busy_q;
    assign bus.err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_module_reg_access_ctrl.sv
// Bench for module_reg_access_ctrl: 3 registers, register 0 read-only.
// Stimulus pushes expected strobes/acks into queues; a negedge monitor pops and compares.
module tb_module_reg_access_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_pass;
    int   n_total;

    typedef struct {
        logic [2:0]  en;
        logic [31:0] dat;
        int          cyc;
    } strb_t;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        logic [7:0]  cnt;
        int          cyc;
    } ack_t;

    strb_t strb_q[$];
    ack_t  ack_q[$];

    logic [31:0] bank [3];
    logic [31:0] hold_rdata;
    logic [7:0]  exp_cnt;

    module_reg_access_ctrl_if #(.NUM_REGS(3), .ADDR_W(2), .DATA_W(32)) bus ();

    module_reg_access_ctrl #(
        .NUM_REGS (3),
        .ADDR_W   (2),
        .DATA_W   (32),
        .RO_MASK  (3'b001)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor: every strobe or ack the DUT shows must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en_o != 3'b000) begin
                if (strb_q.size() == 0) begin
                    chk("unexpected_strobe", {61'd0, bus.wr_en_o}, 64'd0);
                end else begin
                    strb_t s;
                    s = strb_q.pop_front();
                    chk("strobe_onehot", {61'd0, bus.wr_en_o}, {61'd0, s.en});
                    chk("strobe_data", {32'd0, bus.wr_data_o}, {32'd0, s.dat});
                    chk("strobe_cycle", 64'(cyc), 64'(s.cyc));
                    chk("strobe_busy", {63'd0, bus.busy_o}, 64'd1);
                end
            end
            if (bus.ack_o) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", {63'd0, bus.ack_o}, 64'd0);
                end else begin
                    ack_t r;
                    r = ack_q.pop_front();
                    chk("ack_err", {63'd0, bus.err_o}, {63'd0, r.err});
                    chk("ack_rdata", {32'd0, bus.rdata_o}, {32'd0, r.rd});
                    chk("ack_err_cnt", {56'd0, bus.err_cnt_o}, {56'd0, r.cnt});
                    chk("ack_cycle", 64'(cyc), 64'(r.cyc));
                    chk("ack_busy", {63'd0, bus.busy_o}, 64'd1);
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy_o) chk("idle_wait", {63'd0, bus.busy_o}, 64'd0);
    endtask

    task automatic push_expect(input bit we, input logic [1:0] a, input logic [31:0] wd,
                               input bit clr, input int c);
        bit    e;
        strb_t s;
        ack_t  r;
        e = (a >= 2'd3) || (we && a == 2'd0);
        if (!we) hold_rdata = e ? 32'd0 : bank[a];
        if (e) exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
        if (clr) exp_cnt = e ? 8'd1 : 8'd0;
        if (we && !e) begin
            s.en  = 3'b001 << a;
            s.dat = wd;
            s.cyc = c + 1;
            strb_q.push_back(s);
        end
        r.err = e;
        r.rd  = hold_rdata;
        r.cnt = exp_cnt;
        r.cyc = c + 2;
        ack_q.push_back(r);
    endtask

    task automatic access(input bit we, input logic [1:0] a, input logic [31:0] wd, input bit clr);
        wait_idle();
        push_expect(we, a, wd, clr, cyc);
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.addr_i  = a;
        bus.wdata_i = wd;
        @(posedge clk);
        #1 bus.req_i = 1'b0;
        if (clr) begin
            bus.err_clr_i = 1'b1;
            @(posedge clk);
            #1 bus.err_clr_i = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int c;
        n_pass        = 0;
        n_total       = 0;
        exp_cnt       = 8'd0;
        hold_rdata    = 32'd0;
        bank[0]       = 32'h1111_0000;
        bank[1]       = 32'h0000_00A5;
        bank[2]       = 32'hCAFE_F00D;
        rst_n         = 1'b0;
        bus.req_i     = 1'b0;
        bus.we_i      = 1'b0;
        bus.addr_i    = 2'd0;
        bus.wdata_i   = 32'd0;
        bus.err_clr_i = 1'b0;
        bus.rd_data_i = {bank[2], bank[1], bank[0]};
        #22 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wr_en", {61'd0, bus.wr_en_o}, 64'd0);
        chk("rst_wr_data", {32'd0, bus.wr_data_o}, 64'd0);
        chk("rst_rdata", {32'd0, bus.rdata_o}, 64'd0);
        chk("rst_ack_err", {62'd0, bus.ack_o, bus.err_o}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy_o}, 64'd0);
        chk("rst_err_cnt", {56'd0, bus.err_cnt_o}, 64'd0);

        access(1'b1, 2'd2, 32'hDEADBEEF, 1'b0);
        access(1'b0, 2'd1, 32'h0, 1'b0);
        access(1'b1, 2'd3, 32'h1234_5678, 1'b0);
        access(1'b1, 2'd0, 32'h0BAD_0BAD, 1'b0);
        access(1'b0, 2'd0, 32'h0, 1'b0);
        access(1'b0, 2'd3, 32'h0, 1'b0);

        // Held request for six edges: accepted at the first and fourth only.
        wait_idle();
        c = cyc;
        push_expect(1'b1, 2'd1, 32'h5555_AAAA, 1'b0, c);
        push_expect(1'b1, 2'd1, 32'h5555_AAAA, 1'b0, c + 3);
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.addr_i  = 2'd1;
        bus.wdata_i = 32'h5555_AAAA;
        repeat (6) @(posedge clk);
        #1 bus.req_i = 1'b0;

        wait_idle();
        bus.err_clr_i = 1'b1;
        @(posedge clk);
        #1 bus.err_clr_i = 1'b0;
        exp_cnt = 8'd0;
        @(negedge clk);
        chk("clr_alone", {56'd0, bus.err_cnt_o}, 64'd0);

        for (int i = 0; i < 256; i++) access(1'b0, 2'd3, 32'h0, 1'b0);
        wait_idle();
        chk("cnt_saturated", {56'd0, bus.err_cnt_o}, 64'd255);
        access(1'b1, 2'd3, 32'h0, 1'b1);

        // Reset while the write strobe is live: everything drops, no ack later.
        wait_idle();
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.addr_i  = 2'd2;
        bus.wdata_i = 32'hFEED_FACE;
        @(posedge clk);
        #1 bus.req_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", {61'd0, bus.wr_en_o}, 64'd0);
        chk("midrst_wr_data", {32'd0, bus.wr_data_o}, 64'd0);
        chk("midrst_busy", {63'd0, bus.busy_o}, 64'd0);
        chk("midrst_err_cnt", {56'd0, bus.err_cnt_o}, 64'd0);
        exp_cnt    = 8'd0;
        hold_rdata = 32'd0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", {63'd0, bus.busy_o}, 64'd0);

        access(1'b1, 2'd1, 32'h0F0F_0F0F, 1'b0);
        access(1'b0, 2'd2, 32'h0, 1'b0);
        repeat (5) @(negedge clk);
        chk("strobe_queue_empty", 64'(strb_q.size()), 64'd0);
        chk("ack_queue_empty", 64'(ack_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
